// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types, counter encodings and the saturating-counter
//               update helper for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  typedef logic [1:0] counter_t;

  localparam counter_t CNT_SNT   = 2'd0;  // strongly not-taken
  localparam counter_t CNT_WNT   = 2'd1;  // weakly not-taken
  localparam counter_t CNT_WT    = 2'd2;  // weakly taken
  localparam counter_t CNT_ST    = 2'd3;  // strongly taken
  localparam counter_t CNT_RESET = CNT_WNT;

  // Two-bit saturating step toward the resolved direction.
  function automatic counter_t sat_update(input counter_t c, input logic taken);
    counter_t nxt;
    nxt = c;
    if (taken) begin
      if (c != CNT_ST) nxt = c + 2'd1;
    end else begin
      if (c != CNT_SNT) nxt = c - 2'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_btb.sv
`default_nettype none
// ============================================================================
// Module      : bp_btb
// Description : Direct-mapped branch target buffer (valid / tag / target).
//               One lookup port for fetch, one hit-check port for the
//               resolving branch, one write port. The tag is PC bits above
//               the index and disappears when INDEX_W == PC_W.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_btb #(
  parameter int PC_W    = 5,
  parameter int INDEX_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] i_rd_pc,
  output logic            o_rd_hit,
  output logic [PC_W-1:0] o_rd_target,
  input  logic [PC_W-1:0] i_chk_pc,
  output logic            o_chk_hit,
  input  logic            i_wr_en,
  input  logic [PC_W-1:0] i_wr_pc,
  input  logic [PC_W-1:0] i_wr_target
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int TAG_W   = PC_W - INDEX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [PC_W-1:0]    r_target [ENTRIES];

  logic [INDEX_W-1:0] w_rd_idx;
  logic [INDEX_W-1:0] w_chk_idx;
  logic [INDEX_W-1:0] w_wr_idx;
  logic               w_rd_tag_ok;
  logic               w_chk_tag_ok;

  assign w_rd_idx  = i_rd_pc[INDEX_W-1:0];
  assign w_chk_idx = i_chk_pc[INDEX_W-1:0];
  assign w_wr_idx  = i_wr_pc[INDEX_W-1:0];

  // Valid bits and targets: cleared on reset, written on taken resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_target[i] <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx]  <= 1'b1;
      r_target[w_wr_idx] <= i_wr_target;
    end
  end

  generate
    if (TAG_W > 0) begin : g_tag
      logic [TAG_W-1:0] r_tag [ENTRIES];

      // Tag storage follows the same write as the target.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < ENTRIES; i++) r_tag[i] <= '0;
        end else if (i_wr_en) begin
          r_tag[w_wr_idx] <= i_wr_pc[PC_W-1:INDEX_W];
        end
      end

      assign w_rd_tag_ok  = (r_tag[w_rd_idx]  == i_rd_pc[PC_W-1:INDEX_W]);
      assign w_chk_tag_ok = (r_tag[w_chk_idx] == i_chk_pc[PC_W-1:INDEX_W]);
    end else begin : g_notag
      assign w_rd_tag_ok  = 1'b1;
      assign w_chk_tag_ok = 1'b1;
    end
  endgenerate

  assign o_rd_hit    = r_valid[w_rd_idx] & w_rd_tag_ok;
  assign o_rd_target = r_target[w_rd_idx];
  assign o_chk_hit   = r_valid[w_chk_idx] & w_chk_tag_ok;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Fetch-stage direction/target predictor. 2-bit saturating
//               counter table plus a direct-mapped target buffer, trained by
//               branches resolved in Execute. Zero-latency lookup, no bypass
//               of a same-cycle update.
//               Optional macro BRANCH_PREDICTOR_GSHARE_EN: the counter table
//               is indexed by PC XOR global history (target buffer stays
//               PC-indexed).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W    = 5,
  parameter int INDEX_W = 5,
  parameter int CNT_W   = 16,
  parameter int GHR_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc_F,
  output logic             predict_taken_F,
  output logic [PC_W-1:0]  predict_target_F,
  output logic [GHR_W-1:0] ghr_F,
  input  logic             update_signal_E,
  input  logic [PC_W-1:0]  pc_E,
  input  logic [GHR_W-1:0] ghr_E,
  input  logic             actual_outcome_E,
  input  logic             prediction_E,
  input  logic [PC_W-1:0]  target_E,
  output logic             mispredict_E,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 2 ** INDEX_W;

  counter_t           r_cnt [ENTRIES];
  logic [CNT_W-1:0]   r_mcount;

  logic [INDEX_W-1:0] w_cidx_F;
  logic [INDEX_W-1:0] w_cidx_E;
  logic               w_btb_hit_F;
  logic [PC_W-1:0]    w_btb_target_F;
  logic               w_btb_hit_E;
  logic               w_btb_we;
  logic               w_cnt_we;

  assign w_btb_we = update_signal_E & actual_outcome_E;
  // A not-taken branch only trains a counter that already belongs to it.
  assign w_cnt_we = update_signal_E & (actual_outcome_E | w_btb_hit_E);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GHR_W-1:0] r_ghr;

  assign w_cidx_F = pc_F[INDEX_W-1:0] ^ INDEX_W'(r_ghr);
  assign w_cidx_E = pc_E[INDEX_W-1:0] ^ INDEX_W'(ghr_E);
  assign ghr_F    = r_ghr;

  // Global history shifts in every resolved outcome.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ghr <= '0;
    end else if (update_signal_E) begin
      r_ghr <= GHR_W'({r_ghr, actual_outcome_E});
    end
  end
`else
  logic w_unused_ghr_e;

  assign w_cidx_F       = pc_F[INDEX_W-1:0];
  assign w_cidx_E       = pc_E[INDEX_W-1:0];
  assign ghr_F          = '0;
  assign w_unused_ghr_e = ^ghr_E;
`endif

  bp_btb #(
    .PC_W    (PC_W),
    .INDEX_W (INDEX_W)
  ) u_btb (
    .clk         (clk),
    .rst_n       (reset),
    .i_rd_pc     (pc_F),
    .o_rd_hit    (w_btb_hit_F),
    .o_rd_target (w_btb_target_F),
    .i_chk_pc    (pc_E),
    .o_chk_hit   (w_btb_hit_E),
    .i_wr_en     (w_btb_we),
    .i_wr_pc     (pc_E),
    .i_wr_target (target_E)
  );

  // Counter table: reset to weakly not-taken, saturating training from E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_RESET;
    end else if (w_cnt_we) begin
      r_cnt[w_cidx_E] <= sat_update(r_cnt[w_cidx_E], actual_outcome_E);
    end
  end

  // Read-only lookup; fall through to the sequential PC when not taken.
  assign predict_taken_F  = r_cnt[w_cidx_F][1] & w_btb_hit_F;
  assign predict_target_F = predict_taken_F ? w_btb_target_F : (pc_F + PC_W'(1));

  assign mispredict_E = update_signal_E & (actual_outcome_E != prediction_E);

  // Misprediction statistics, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcount <= '0;
    end else if (mispredict_E && (r_mcount != '1)) begin
      r_mcount <= r_mcount + CNT_W'(1);
    end
  end

  assign mispredict_count = r_mcount;

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage direction/target predictor for the pipelined MIPS core.
- Supplies predict_taken_F / predict_target_F to the PC-select mux.
- Consumes resolved-branch information from Execute: update_signal_E, actual_outcome_E, prediction_E, target.
- Produces mispredict_E, which the hazard unit turns into flush.
- Storage: table of 2-bit saturating counters plus a direct-mapped target buffer, with an optional global-history (gshare) index.

Parameters:
- PC_W, 5, width of PC and branch targets.
- INDEX_W, 5, log2 of table entries; must satisfy INDEX_W <= PC_W.
- CNT_W, 16, width of the saturating misprediction statistics counter.
- GHR_W, 4, global history length; used only with GSHARE_EN, and must satisfy GHR_W <= INDEX_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_F  in  PC_W  fetch PC.
- predict_taken_F  out  1  predict taken for pc_F.
- predict_target_F  out  PC_W  predicted target for pc_F.
- ghr_F  out  GHR_W  history snapshot for pc_F; pipeline carries it to E; reads 0 without GSHARE_EN.
- update_signal_E  in  1  branch resolved in E this cycle.
- pc_E  in  PC_W  PC of the resolving branch.
- ghr_E  in  GHR_W  ghr_F value carried with that branch; ignored without GSHARE_EN.
- actual_outcome_E  in  1  branch actually taken.
- prediction_E  in  1  predict_taken_F value carried with the branch.
- target_E  in  PC_W  computed branch target.
- mispredict_E  out  1  update_signal_E & (actual_outcome_E != prediction_E).
- mispredict_count  out  CNT_W  saturating count of mispredictions.

Behaviour:
Storage
- Per entry: 2-bit counter, valid bit, target, and tag (tag = pc[PC_W-1:INDEX_W]; zero width when INDEX_W == PC_W).
- Index: idx(pc) = pc[INDEX_W-1:0].

Lookup (combinational, zero latency)
- predict_taken_F = cnt[idx][1] & valid[idx] & tag match.
- predict_target_F = target[idx] when predicting taken, else pc_F+1 (modulo 2^PC_W).

Update (rising clk with update_signal_E = 1)
- Counter: increment saturating at 3 if actual_outcome_E, else decrement saturating at 0.
- Taken branch: write target_E and tag, set valid.
- Not-taken branch that misses the tag: no allocation, counter untouched.
- Tag hit: counter updates as above.

Simultaneous lookup/update on the same index
- Lookup returns the pre-update value; no bypass.

mispredict_E
- Purely combinational.
- mispredict_count increments on each clk edge where mispredict_E = 1 and saturates at all-ones.

Reset (reset = 0, asynchronous, any time including mid-update)
- All counters = 2'b01 (weakly not-taken), all valid = 0, targets and tags = 0, GHR = 0, mispredict_count = 0.
- Outputs therefore read predict_taken_F = 0, predict_target_F = pc_F+1, ghr_F = 0, mispredict_E follows its inputs.
- First update is accepted on the first rising edge after reset deasserts.

Other
- Pipeline stall does not gate updates: E-stage resolution is always applied.
- X/unknown pc_F must not corrupt state: lookup is read-only.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - A GHR_W-bit global history register shifts left on every update, inserting actual_outcome_E.
  - Counter index = pc[INDEX_W-1:0] XOR zero-extended GHR for lookup, and XOR zero-extended ghr_E for update.
  - ghr_F = current GHR.
  - Target buffer remains PC-indexed.
- Undefined: no GHR; counter index = PC bits; ghr_F = 0; ghr_E ignored.

Decomposition:
- Shared package bp_pkg holds:
  - counter typedef counter_t (2 bits);
  - constants CNT_SNT = 0, CNT_WNT = 1, CNT_WT = 2, CNT_ST = 3;
  - CNT_RESET = CNT_WNT;
  - function sat_update(counter_t, taken).
- One natural sub-module, bp_btb: valid/tag/target storage with its own lookup and write.
- Counter table and GHR stay in branch_predictor.

Test Plan:
- Reset released, pc_F = 5 -> predict_taken_F = 0, predict_target_F = 6, mispredict_count = 0.
- Update pc_E = 5, target_E = 20, taken, prediction_E = 0, twice:
  - mispredict_E = 1 both cycles, mispredict_count = 2;
  - pc_F = 5 then predicts taken, target 20 (counter 1->2->3).
- Counter at 3, four not-taken updates at pc_E = 5:
  - predict_taken_F goes 1, 0, 0, 0 after each edge; counter stays at 0 without underflow.
- Same-cycle lookup and update at pc = 5 (counter 1, taken) -> lookup shows 0 in that cycle, 1 the next cycle.
- Assert reset = 0 asynchronously between edges while update_signal_E = 1 -> all state cleared immediately, update lost, pc_F = 31 predicts target 0 (wrap).
- With BRANCH_PREDICTOR_GSHARE_EN:
  - taken updates at pc_E = 2 with ghr_E = 0 then ghr_E = 1 train distinct counters (indices 2 and 3);
  - ghr_F reads 4'b0011 after two taken updates.
